// File: rtl/instruction_sp_fifo.sv
// Synchronous FIFO on a single-port RAM: at most one RAM access per clock.
// A write takes priority over a read for the RAM port unless the FIFO is full,
// in which case the write is dropped and the read proceeds.
//
// Ports:
//   clk        - system clock, rising-edge
//   rst        - asynchronous active-low reset
//   inst       - command word {WE, RE, DI[WIDTH-1:0]}
//   res        - registered read data, holds its value between pops
//   read_valid - one-cycle strobe, high when res carries a newly popped word
module instruction_sp_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH+1:0] inst,
  output logic [WIDTH-1:0] res,
  output logic             read_valid
);

  localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

  logic             we;
  logic             re;
  logic [WIDTH-1:0] di;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    addr;

  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  logic [WIDTH-1:0] mem [DEPTH];

  assign we = inst[WIDTH+1];
  assign re = inst[WIDTH];
  assign di = inst[WIDTH-1:0];

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // Write owns the single RAM port whenever it is accepted; a read only gets
  // the port in cycles with no accepted write.
  assign wr_acc = we && !full;
  assign rd_acc = re && !empty && !wr_acc;

  assign addr = wr_acc ? wptr_q : rptr_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) begin
      wptr_d  = wptr_q + AW'(1);
      count_d = count_q + (AW+1)'(1);
    end else if (rd_acc) begin
      rptr_d  = rptr_q + AW'(1);
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // RAM array is never reset; only the write side of the port lives here.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[addr] <= di;
    end
  end

  // Registered read port of the RAM doubles as the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res        <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_acc;
      if (rd_acc) begin
        res <= mem[addr];
      end
    end
  end

endmodule

// File: tb/tb_instruction_sp_fifo.sv
module tb_instruction_sp_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH+1:0] inst;
  logic [WIDTH-1:0] res;
  logic             read_valid;

  int n_pass;
  int n_checks;

  logic [31:0] model_q [$];  // behavioural FIFO contents
  logic [31:0] sb_q    [$];  // expected popped words, in order
  logic [31:0] got_q   [$];  // words actually popped in the current test
  logic [31:0] exp_seq [$];
  logic [31:0] last_res;

  instruction_sp_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .res       (res),
    .read_valid(read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one command for one clock, update the model, check outputs after the edge.
  task automatic step(input logic we, input logic re, input logic [31:0] di);
    logic wacc;
    logic racc;
    logic [31:0] e;
    inst = {we, re, di};
    wacc = we && (model_q.size() != DEPTH);
    racc = re && (model_q.size() != 0) && !wacc;
    if (racc) sb_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(di);
    @(posedge clk);
    #1;
    check("read_valid", {31'b0, read_valid}, {31'b0, racc});
    if (racc) begin
      e = sb_q.pop_front();
      check("res_pop", res, e);
      last_res = e;
      got_q.push_back(res);
    end else begin
      check("res_hold", res, last_res);
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    inst = '0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_res", res, 32'h0);
    check("rst_valid", {31'b0, read_valid}, 32'h0);
    model_q.delete();
    sb_q.delete();
    got_q.delete();
    last_res = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < got_q.size(); i++) begin
      check(tag, got_q[i], exp_seq[i]);
    end
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    last_res = '0;
    rst      = 1'b0;
    inst     = '0;
    #1;
    check("init_res", res, 32'h0);
    check("init_valid", {31'b0, read_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Empty read right after reset
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);
    check("empty_res", res, 32'h0);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b0, 32'(i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("fill_hold", res, 32'd8);
    check("fill_idle_valid", {31'b0, read_valid}, 32'h0);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_seq("fill_seq");

    // Write two then conflict
    do_reset();
    step(1'b1, 1'b0, 32'd1);
    step(1'b1, 1'b0, 32'd2);
    step(1'b1, 1'b1, 32'd3);
    check("conflict_no_pop", {31'b0, read_valid}, 32'h0);
    for (int i = 4; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h0);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_seq("conflict_seq");

    // Full then simultaneous
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
    for (int i = 9; i <= 12; i++) step(1'b1, 1'b1, 32'(i));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 32'h0);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 12};
    check_seq("full_sim_seq");

    // Wrap-around
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);
    for (int i = 6; i <= 12; i++) step(1'b1, 1'b0, 32'(i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h0);
    check("wrap_end_valid", {31'b0, read_valid}, 32'h0);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    check_seq("wrap_seq");

    // Reset mid-operation
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i));
    step(1'b0, 1'b1, 32'h0);
    inst = {1'b0, 1'b1, 32'h0};
    #2;
    rst = 1'b0;
    #1;
    check("midrst_res", res, 32'h0);
    check("midrst_valid", {31'b0, read_valid}, 32'h0);
    model_q.delete();
    sb_q.delete();
    got_q.delete();
    last_res = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h99);
    step(1'b0, 1'b1, 32'h0);
    exp_seq = '{32'h99};
    check_seq("midrst_seq");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_sp_fifo.md
Name: instruction_sp_fifo

Overview:
- Synchronous FIFO built on one single-port RAM, so at most one RAM access (read or write) happens per clock.
- Driven by a packed command word: write-enable, read-enable and write data.
- Returns registered read data with a one-cycle valid strobe.
- Sits between a command source and a consumer; the source has no backpressure.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 8, number of FIFO entries; must be a power of two.
- AW, 3, address width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst  input  WIDTH+2  command word: bit WIDTH+1 = WE, bit WIDTH = RE, bits WIDTH-1:0 = DI (write data).
- res  output  WIDTH  registered read data.
- read_valid  output  1  high for one cycle when res carries a newly popped word.

Behaviour:
- Reset (rst low, asynchronous): write pointer, read pointer and count go to 0; res = 0; read_valid = 0. RAM contents are not cleared. Reset takes effect immediately, including in the middle of any operation; all pending requests are discarded.
- Status flags (internal): empty when count == 0; full when count == DEPTH. Count ranges 0..DEPTH and is AW+1 bits wide.
- Write accepted when WE == 1 and not full.
  - RAM[wptr] <= DI at the clock edge.
  - wptr increments, wrapping modulo DEPTH.
  - count increments.
- Write with WE == 1 while full: DI is dropped silently; no state change.
- Read accepted when RE == 1, not empty, and no write is accepted in the same cycle.
  - RAM[rptr] is read.
  - rptr increments, wrapping modulo DEPTH.
  - count decrements.
- Read latency: one cycle. The popped word appears on res and read_valid = 1 in the cycle after the read is accepted.
- When no read was accepted in the previous cycle: read_valid = 0 and res holds its last value.
- Read with RE == 1 while empty: ignored; read_valid stays 0.
- Port arbitration when WE == 1 and RE == 1 in the same cycle (conflict):
  - Not full: the write wins the RAM port; the read is not performed that cycle (no pop, read_valid = 0 next cycle). RE is level-sensitive, so the read is retried automatically while RE stays high.
  - Full: the write is dropped and the read proceeds.
  - Consequence: continuous WE+RE on a full FIFO alternates pop / push each cycle.
- Ordering: strict first-in first-out. Pointer wrap-around is transparent to the user.
- No bypass path: data written in cycle N can be read no earlier than cycle N+1.
- The RAM is a single-port synchronous array with one address mux (wptr when writing, rptr otherwise) and a registered read output.

Test Plan:
- Fill and overflow: release reset; WE = 1, RE = 0 for 12 cycles with DI = 1..12 -> words 1..8 stored and 9..12 dropped. Then RE = 1, WE = 0 -> res = 1,2,…,8 on consecutive cycles with read_valid = 1. After that read_valid = 0 and res holds 8.
- Write-two then conflict: write 1, 2; next cycle WE = RE = 1, DI = 3 -> 3 written, no pop, read_valid = 0. Then write 4..8 with RE = 0; then RE only -> res = 1..8 in order.
- Full then simultaneous: write 1..8 to full; then WE = RE = 1 with DI = 9,10,11,12 -> 9 dropped, pop 1; 10 written; 11 dropped, pop 2; 12 written. Draining afterwards yields 3,4,5,6,7,8,10,12.
- Wrap-around: write 1..5, read 5 (res = 1..5), write 6..12 -> pointers wrap past entry 7; reading all yields 6..12 in order, then read_valid = 0.
- Empty read: RE = 1 right after reset -> read_valid stays 0 and res stays 0.
- Reset mid-operation: after writing 1..4, pull rst low while RE = 1 -> res = 0 and read_valid = 0 immediately. After release, RE = 1 produces no valid data until a new write occurs.
